// File: rtl/oled_spi_rx.sv
// Receive-side decoder for the 4-wire OLED serial bus: oversamples, assembles MSB-first bytes,
// tracks SSD1306 page/column addressing and emits shadow frame-buffer writes. OLED_RX_ARGSKIP_EN enables command-argument skipping.
module oled_spi_rx #(
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       oled_rst,
  input  logic       oled_dcn,
  input  logic       oled_clk,
  input  logic       oled_dat,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic       fb_we,
  output logic [9:0] fb_addr,
  output logic [7:0] fb_wdata,
  output logic       disp_on,
  output logic       frame_err
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  logic          r_rst_s1, r_rst_s2;
  logic          r_dcn_s1, r_dcn_s2;
  logic          r_clk_s1, r_clk_s2, r_clk_s3;
  logic          r_dat_s1, r_dat_s2;
  logic [6:0]    r_shift;
  logic [2:0]    r_bitcnt;
  logic [IW-1:0] r_idle;
  logic          r_done;
  logic [7:0]    r_done_byte;
  logic          r_done_dc;
  logic [2:0]    r_page;
  logic [6:0]    r_col;
  logic          w_edge;
  logic          w_orst_n;
  logic          w_cmd_en;

`ifdef OLED_RX_ARGSKIP_EN
  typedef enum logic [1:0] {CMD = 2'd0, ARG1 = 2'd1, ARG2 = 2'd2} state_t;
  state_t r_state;
  assign w_cmd_en = (r_state == CMD);
`else
  assign w_cmd_en = 1'b1;
`endif

  assign w_edge   = r_clk_s2 & ~r_clk_s3;
  assign w_orst_n = r_rst_s2;
  assign fb_wdata = rx_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rst_s1 <= 1'b0;
      r_rst_s2 <= 1'b0;
      r_dcn_s1 <= 1'b0;
      r_dcn_s2 <= 1'b0;
      r_clk_s1 <= 1'b0;
      r_clk_s2 <= 1'b0;
      r_clk_s3 <= 1'b0;
      r_dat_s1 <= 1'b0;
      r_dat_s2 <= 1'b0;
    end else begin
      r_rst_s1 <= oled_rst;
      r_rst_s2 <= r_rst_s1;
      r_dcn_s1 <= oled_dcn;
      r_dcn_s2 <= r_dcn_s1;
      r_clk_s1 <= oled_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_dat_s1 <= oled_dat;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Bit assembly; the completed byte is handed to the decode stage one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_idle      <= '0;
      r_done      <= 1'b0;
      r_done_byte <= '0;
      r_done_dc   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      frame_err <= 1'b0;
      if (!w_orst_n) begin
        r_bitcnt <= '0;
        r_idle   <= '0;
      end else if (w_edge) begin
        r_idle  <= '0;
        r_shift <= {r_shift[5:0], r_dat_s2};
        if (r_bitcnt == 3'd7) begin
          r_bitcnt    <= '0;
          r_done      <= 1'b1;
          r_done_byte <= {r_shift, r_dat_s2};
          r_done_dc   <= r_dcn_s2;
        end else begin
          r_bitcnt <= r_bitcnt + 3'd1;
        end
      end else if (r_idle != IW'(IDLE_TIMEOUT)) begin
        // Counter saturates at the limit so a stalled partial byte reports only once.
        r_idle <= r_idle + 1'b1;
        if ((r_idle == IW'(IDLE_TIMEOUT - 1)) && (r_bitcnt != 3'd0)) begin
          r_bitcnt  <= '0;
          frame_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid <= 1'b0;
      rx_byte  <= '0;
      rx_dc    <= 1'b0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      disp_on  <= 1'b0;
      r_page   <= '0;
      r_col    <= '0;
`ifdef OLED_RX_ARGSKIP_EN
      r_state  <= CMD;
`endif
    end else begin
      rx_valid <= 1'b0;
      fb_we    <= 1'b0;
      if (!w_orst_n) begin
        r_page  <= '0;
        r_col   <= '0;
        disp_on <= 1'b0;
`ifdef OLED_RX_ARGSKIP_EN
        r_state <= CMD;
`endif
      end else if (r_done) begin
        rx_valid <= 1'b1;
        rx_byte  <= r_done_byte;
        rx_dc    <= r_done_dc;
        if (r_done_dc) begin
          fb_we   <= 1'b1;
          fb_addr <= {r_page, r_col};
          r_col   <= r_col + 7'd1;
`ifdef OLED_RX_ARGSKIP_EN
          r_state <= CMD;
`endif
        end else begin
          if (w_cmd_en) begin
            casez (r_done_byte)
              8'b1011_0???: r_page     <= r_done_byte[2:0];
              8'b0000_????: r_col[3:0] <= r_done_byte[3:0];
              8'b0001_0???: r_col[6:4] <= r_done_byte[2:0];
              8'hAE:        disp_on    <= 1'b0;
              8'hAF:        disp_on    <= 1'b1;
              default:      ;
            endcase
          end
`ifdef OLED_RX_ARGSKIP_EN
          case (r_state)
            CMD: begin
              case (r_done_byte)
                8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
                8'hD5, 8'hD9, 8'hDA, 8'hDB: r_state <= ARG1;
                8'h21, 8'h22:               r_state <= ARG2;
                default:                    r_state <= CMD;
              endcase
            end
            ARG2:    r_state <= ARG1;
            default: r_state <= CMD;
          endcase
`endif
        end
      end
    end
  end

endmodule
